ws_psum_collector: RTL and testbench

// Downstream stage of the weight-stationary NxN systolic array: consumes the skewed bottom-edge partial

---
 rtl/ws_pkg.sv | 25 ++
 rtl/ws_row_fifo.sv | 56 +++++
 rtl/ws_psum_collector.sv | 121 ++++++++++++
 tb/tb_ws_psum_collector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// ============================================================================
// ws_pkg: shared widths, row types and sign extension for the psum collector
// Rev 1.0
// ============================================================================
`default_nettype none

package ws_pkg;

    localparam int D_W_DEF    = 8;
    localparam int N_DEF      = 4;
    localparam int ACC_W_DEF  = 32;
    localparam int ROWS_DEF   = 4;
    localparam int FIFO_D_DEF = 8;

    typedef logic signed [2*D_W_DEF-1:0]             psum_t;
    typedef logic signed [ACC_W_DEF-1:0]             acc_t;
    typedef logic signed [N_DEF-1:0][ACC_W_DEF-1:0]  acc_row_t;

    function automatic acc_t sext(input psum_t p);
        return acc_t'(p);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws_row_fifo.sv
// ============================================================================
// ws_row_fifo: first-word-fall-through row FIFO; a push into a full FIFO with no
// concurrent pop is dropped and flagged. Rev 1.0
// ============================================================================
`default_nettype none

module ws_row_fifo #(
    parameter  int W     = 128,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          drop_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, do_pop, do_push;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // At full the write slot is the head being popped, so push+pop both succeed.
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & full & ~do_pop;
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/ws_psum_collector.sv
// ============================================================================
// ws_psum_collector: deskews systolic bottom-edge psums, accumulates K-tiles per
// row and queues finished rows with credit-based flow control. Rev 1.0
// ============================================================================
`default_nettype none

module ws_psum_collector
    import ws_pkg::*;
#(
    parameter int D_W    = D_W_DEF,
    parameter int N      = N_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int FIFO_D = FIFO_D_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic                       in_first_i,
    input  logic                       in_last_i,
    input  logic [N-1:0][2*D_W-1:0]    in_sum_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N-1:0][ACC_W-1:0]    out_data_o,
    output logic                       overflow_o
);

    localparam int PW    = 2 * D_W;
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = $clog2(FIFO_D + 1);

    logic [N-1:0][PW-1:0]             aligned;
    logic [N-2:0]                     vld_dl_q, first_dl_q, last_dl_q;
    logic [ROWS-1:0][N-1:0][ACC_W-1:0] acc_q;
    logic [N-1:0][ACC_W-1:0]          row_d;
    logic [IDX_W-1:0]                 idx_q;
    logic                             overflow_q;
    logic                             a_valid, a_first, a_last;
    logic                             fifo_empty, fifo_drop;
    logic [CW-1:0]                    fifo_count;

    // Column c arrives c cycles after column 0, so it waits N-1-c cycles.
    for (genvar c = 0; c < N; c++) begin : g_col
        if (c == N - 1) begin : g_direct
            assign aligned[c] = in_sum_i[c];
        end else begin : g_delay
            localparam int DEP = N - 1 - c;
            logic [DEP-1:0][PW-1:0] sum_dl_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_dl_q <= '0;
                end else begin
                    sum_dl_q[0] <= in_sum_i[c];
                    for (int k = 1; k < DEP; k++) sum_dl_q[k] <= sum_dl_q[k-1];
                end
            end
            assign aligned[c] = sum_dl_q[DEP-1];
        end
    end

    assign a_valid = vld_dl_q[N-2];
    assign a_first = first_dl_q[N-2];
    assign a_last  = last_dl_q[N-2];

    always_comb begin
        row_d = '0;
        for (int c = 0; c < N; c++) begin
            row_d[c] = a_first ? ACC_W'($signed(aligned[c]))
                               : acc_q[idx_q][c] + ACC_W'($signed(aligned[c]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_dl_q   <= '0;
            first_dl_q <= '0;
            last_dl_q  <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_dl_q[0]   <= in_valid_i;
            first_dl_q[0] <= in_valid_i & in_first_i;
            last_dl_q[0]  <= in_valid_i & in_last_i;
            for (int k = 1; k < N - 1; k++) begin
                vld_dl_q[k]   <= vld_dl_q[k-1];
                first_dl_q[k] <= first_dl_q[k-1];
                last_dl_q[k]  <= last_dl_q[k-1];
            end
            if (a_valid) begin
                acc_q[idx_q] <= row_d;
                idx_q        <= (idx_q == IDX_W'(ROWS-1)) ? '0 : idx_q + 1'b1;
            end
            overflow_q <= overflow_q | fifo_drop;
        end
    end

    ws_row_fifo #(
        .W     (N * ACC_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (a_valid & a_last),
        .data_i  (row_d),
        .pop_i   (out_ready_i),
        .data_o  (out_data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    // Rows already in the deskew line hold a reserved FIFO slot.
    assign in_ready_o  = (FIFO_D - int'(fifo_count) - $countones(last_dl_q)) >= 1;
    assign out_valid_o = ~fifo_empty;
    assign overflow_o  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ws_psum_collector.sv
// ============================================================================
// tb_ws_psum_collector: directed checks of deskew, accumulation, FIFO, credit
// and reset behaviour. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ws_psum_collector;
    import ws_pkg::*;

    localparam int N    = 4;
    localparam int MAXC = 128;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_first, in_last, out_ready;
    logic [N-1:0][15:0]   in_sum;
    logic                 in_ready, out_valid, overflow;
    acc_row_t             out_data;

    logic                 wf_v [MAXC];
    logic                 wf_f [MAXC];
    logic                 wf_l [MAXC];
    logic [N-1:0][15:0]   wf_d [MAXC];
    logic [127:0]         got_q [$];
    int                   cyc;
    int                   n_checks = 0;
    int                   n_errors = 0;

    ws_psum_collector #(
        .D_W(8), .N(N), .ACC_W(32), .ROWS(4), .FIFO_D(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_first_i (in_first),
        .in_last_i  (in_last),
        .in_sum_i   (in_sum),
        .in_ready_o (in_ready),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0][15:0] mk_in(input int n);
        logic [N-1:0][15:0] r;
        for (int c = 0; c < N; c++) r[c] = 16'(16 * n + c);
        return r;
    endfunction

    function automatic logic [127:0] mk_exp(input int n);
        logic [N-1:0][31:0] r;
        for (int c = 0; c < N; c++) r[c] = 32'(16 * n + c);
        return r;
    endfunction

    task automatic clear_sched();
        cyc = 0;
        for (int i = 0; i < MAXC; i++) begin
            wf_v[i] = 1'b0; wf_f[i] = 1'b0; wf_l[i] = 1'b0; wf_d[i] = '0;
        end
        got_q.delete();
    endtask

    task automatic start_wf(input logic f, input logic l, input logic [N-1:0][15:0] d);
        wf_v[cyc] = 1'b1; wf_f[cyc] = f; wf_l[cyc] = l; wf_d[cyc] = d;
    endtask

    // Drive the skewed inputs of cycle cyc, record any popped row, advance one clock.
    task automatic step();
        in_valid = wf_v[cyc];
        in_first = wf_f[cyc];
        in_last  = wf_l[cyc];
        for (int c = 0; c < N; c++) in_sum[c] = (cyc >= c) ? wf_d[cyc-c][c] : 16'h0;
        if (out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk); #1;
        if (cyc < MAXC - 1) cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sum = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int drop_cyc;
        logic [127:0] exp2 [4];
        logic [127:0] exp3 [4];
        logic [N-1:0][15:0] t1 [4];
        logic [N-1:0][15:0] t2 [4];

        out_ready = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sum = '0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow",  overflow, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_data",  out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: single pass, latency and hold while stalled
        do_reset(); clear_sched(); out_ready = 1'b0;
        start_wf(1'b1, 1'b1, {16'd31, 16'd21, 16'd11, 16'd1});
        repeat (3) step();
        check("t1_not_yet", out_valid, 0);
        step();
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, {32'd31, 32'd21, 32'd11, 32'd1});
        step();
        check("t1_hold", out_data, {32'd31, 32'd21, 32'd11, 32'd1});
        out_ready = 1'b1;
        step();
        check("t1_popped", got_q.size(), 1);
        check("t1_empty", out_valid, 0);

        // Test 2: two K-tiles, wrap-around sums and sign extension
        do_reset(); clear_sched(); out_ready = 1'b1;
        t1[0] = {4{16'd100}};  t2[0] = {4{16'hFFE2}};
        t1[1] = {4{16'd0}};    t2[1] = {4{16'hFF00}};
        t1[2] = {4{16'd0}};    t2[2] = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001};
        t1[3] = {4{16'd5}};    t2[3] = {4{16'hFFFB}};
        exp2[0] = {4{32'd70}};
        exp2[1] = {4{32'hFFFFFF00}};
        exp2[2] = {32'hFFFFFFFF, 32'h00007FFF, 32'hFFFF8000, 32'h00000001};
        exp2[3] = {4{32'd0}};
        for (int r = 0; r < 4; r++) begin start_wf(1'b1, 1'b0, t1[r]); step(); step(); end
        for (int r = 0; r < 4; r++) begin start_wf(1'b0, 1'b1, t2[r]); step(); step(); end
        repeat (8) step();
        check("t2_count", got_q.size(), 4);
        for (int r = 0; r < 4; r++) check($sformatf("t2_row%0d", r), got_q[r], exp2[r]);

        // Test 3: 4 rows x 2 K-tiles back-to-back
        do_reset(); clear_sched(); out_ready = 1'b1;
        t1[0] = {16'd4, 16'd3, 16'd2, 16'd1};     t2[0] = {4{16'd100}};
        t1[1] = {16'd40, 16'd30, 16'd20, 16'd10}; t2[1] = {4{16'hFFFF}};
        t1[2] = {4{16'h7FFF}};                    t2[2] = {4{16'h7FFF}};
        t1[3] = {4{16'h8000}};                    t2[3] = {4{16'h8000}};
        exp3[0] = {32'd104, 32'd103, 32'd102, 32'd101};
        exp3[1] = {32'd39, 32'd29, 32'd19, 32'd9};
        exp3[2] = {4{32'h0000FFFE}};
        exp3[3] = {4{32'hFFFF0000}};
        for (int r = 0; r < 4; r++) begin start_wf(1'b1, 1'b0, t1[r]); step(); end
        for (int r = 0; r < 4; r++) begin start_wf(1'b0, 1'b1, t2[r]); step(); end
        repeat (8) step();
        check("t3_count", got_q.size(), 4);
        for (int r = 0; r < 4; r++) check($sformatf("t3_row%0d", r), got_q[r], exp3[r]);

        // Test 4: credit exhaustion, then forced overflow
        do_reset(); clear_sched(); out_ready = 1'b0;
        n = 0; drop_cyc = -1;
        repeat (12) begin
            if (!in_ready && drop_cyc < 0) drop_cyc = cyc;
            if (in_ready) begin start_wf(1'b1, 1'b1, mk_in(n)); n++; end
            step();
        end
        check("t4_accepted", n, 8);
        check("t4_ready_drop_cyc", drop_cyc, 8);
        check("t4_ready_low", in_ready, 0);
        check("t4_full_valid", out_valid, 1);
        start_wf(1'b1, 1'b1, {4{16'h007F}});
        repeat (3) step();
        check("t4_ovf_before", overflow, 0);
        step();
        check("t4_ovf_set", overflow, 1);
        out_ready = 1'b1;
        repeat (10) step();
        check("t4_count", got_q.size(), 8);
        for (int r = 0; r < 8; r++) check($sformatf("t4_row%0d", r), got_q[r], mk_exp(r));
        check("t4_drained", out_valid, 0);
        check("t4_ovf_sticky", overflow, 1);

        // Test 6: reset mid-stream with rows queued and one in flight
        clear_sched(); out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 3) start_wf(1'b1, 1'b1, mk_in(i + 20));
            if (i == 5) start_wf(1'b1, 1'b1, mk_in(30));
            step();
        end
        check("t6_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sum = '0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ovf", overflow, 0);
        check("t6_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_sched();
        start_wf(1'b0, 1'b1, {16'd31, 16'd21, 16'd11, 16'd1});
        repeat (3) step();
        check("t6_no_stale", out_valid, 0);
        step();
        check("t6_valid", out_valid, 1);
        check("t6_data", out_data, {32'd31, 32'd21, 32'd11, 32'd1});

        // Test 5: push and pop on the same edge while full
        do_reset(); clear_sched(); out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) start_wf(1'b1, 1'b1, mk_in(i));
            step();
        end
        check("t5_full_ready", in_ready, 0);
        start_wf(1'b1, 1'b1, mk_in(8));
        repeat (3) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_one_pop", got_q.size(), 1);
        check("t5_ovf", overflow, 0);
        check("t5_still_full", in_ready, 0);
        out_ready = 1'b1;
        repeat (10) step();
        check("t5_count", got_q.size(), 9);
        for (int r = 0; r < 9; r++) check($sformatf("t5_row%0d", r), got_q[r], mk_exp(r));
        check("t5_drained", out_valid, 0);
        check("t5_ovf_end", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
